// File: rtl/sd_sector_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sd_sector_arbiter
// Brief    : Round-robin arbiter that shares the single SD sector channel of
//            the I/O controller between two disk clients. It latches one
//            request at a time, drives the drive-indexed sd_rd/sd_wr bit and
//            the LBA, steers the buffer strobe and data to the granted client,
//            and pulses c_done (with c_err on timeout) when the sector is done.
// Options  : SD_ARB_TIMEOUT_EN - when defined, an ISSUE that gets no sd_ack
//            within TIMEOUT cycles is abandoned and reported with c_err.
//            When undefined, ISSUE waits forever and c_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module sd_sector_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
    input  logic        clk_sys_i,
    input  logic        reset_i,
    // client side
    input  logic [1:0]  c_rd_i,
    input  logic [1:0]  c_wr_i,
    input  logic [31:0] c_lba0_i,
    input  logic [31:0] c_lba1_i,
    output logic [1:0]  c_done_o,
    output logic [1:0]  c_err_o,
    output logic [1:0]  c_busy_o,
    output logic [1:0]  c_buff_wr_o,
    input  logic [7:0]  c_buff_din0_i,
    input  logic [7:0]  c_buff_din1_i,
    // I/O controller side
    output logic [31:0] sd_lba_o,
    output logic [1:0]  sd_rd_o,
    output logic [1:0]  sd_wr_o,
    input  logic        sd_ack_i,
    input  logic        sd_buff_wr_i,
    output logic [7:0]  sd_buff_din_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    // rr_q is the client preferred on the next contention (0 after reset)
    logic        rr_q,    rr_d;
    logic [31:0] lba_q,   lba_d;
    logic [1:0]  rd_q,    rd_d;
    logic [1:0]  wr_q,    wr_d;
    logic [1:0]  done_q,  done_d;
    logic [1:0]  err_q,   err_d;
    logic [1:0]  busy_q,  busy_d;

    logic [1:0]  w_pend;
    logic        w_sel;
    logic [1:0]  w_sel_oh;
    logic        w_sel_wr;
    logic [1:0]  w_grant_oh;
    logic        w_timeout;

    assign w_pend     = c_rd_i | c_wr_i;
    // contention goes to the preferred client, otherwise to whoever asks
    assign w_sel      = (w_pend == 2'b11) ? rr_q : w_pend[1];
    assign w_sel_oh   = w_sel ? 2'b10 : 2'b01;
    // write wins when a client raises both rd and wr
    assign w_sel_wr   = w_sel ? c_wr_i[1] : c_wr_i[0];
    assign w_grant_oh = grant_q ? 2'b10 : 2'b01;

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] cnt_q;

    // ISSUE-cycle counter, cleared while idle so it starts at 0 in ISSUE
    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            cnt_q <= 24'd0;
        end else if (state_q == ST_ISSUE) begin
            cnt_q <= cnt_q + 24'd1;
        end else begin
            cnt_q <= 24'd0;
        end
    end

    // fires in the TIMEOUT-th ISSUE cycle
    assign w_timeout = (cnt_q == (TIMEOUT - 24'd1));
`else
    logic [23:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT;
    assign w_timeout        = 1'b0;
`endif

    // next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        done_d  = 2'b00;
        err_d   = 2'b00;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (|w_pend) begin
                    grant_d = w_sel;
                    lba_d   = w_sel ? c_lba1_i : c_lba0_i;
                    rd_d    = w_sel_wr ? 2'b00 : w_sel_oh;
                    wr_d    = w_sel_wr ? w_sel_oh : 2'b00;
                    busy_d  = w_sel_oh;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (sd_ack_i) begin
                    rd_d    = 2'b00;
                    wr_d    = 2'b00;
                    state_d = ST_XFER;
                end else if (w_timeout) begin
                    rd_d    = 2'b00;
                    wr_d    = 2'b00;
                    done_d  = w_grant_oh;
                    err_d   = w_grant_oh;
                    busy_d  = 2'b00;
                    state_d = ST_DONE;
                end
            end
            ST_XFER: begin
                if (!sd_ack_i) begin
                    done_d  = w_grant_oh;
                    busy_d  = 2'b00;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rr_d    = ~grant_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            rr_q    <= 1'b0;
            lba_q   <= 32'd0;
            rd_q    <= 2'b00;
            wr_q    <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            busy_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // buffer strobe reaches only the granted client, and only during XFER
    always_comb begin
        c_buff_wr_o = 2'b00;
        if (state_q == ST_XFER) begin
            c_buff_wr_o = grant_q ? {sd_buff_wr_i, 1'b0} : {1'b0, sd_buff_wr_i};
        end
    end

    assign sd_buff_din_o = grant_q ? c_buff_din1_i : c_buff_din0_i;
    assign sd_lba_o      = lba_q;
    assign sd_rd_o       = rd_q;
    assign sd_wr_o       = wr_q;
    assign c_done_o      = done_q;
    assign c_busy_o      = busy_q;
`ifdef SD_ARB_TIMEOUT_EN
    assign c_err_o       = err_q;
`else
    logic [1:0] w_unused_err;
    assign w_unused_err  = err_q;
    assign c_err_o       = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sd_sector_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_sector_arbiter
// Brief    : Directed self-checking bench for sd_sector_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_sector_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  c_rd, c_wr;
    logic [31:0] c_lba0, c_lba1;
    logic [1:0]  c_done, c_err, c_busy, c_buff_wr;
    logic [7:0]  c_buff_din0, c_buff_din1;
    logic [31:0] sd_lba;
    logic [1:0]  sd_rd, sd_wr;
    logic        sd_ack, sd_buff_wr;
    logic [7:0]  sd_buff_din;

    int n_vec = 0;
    int n_err = 0;

    sd_sector_arbiter #(.TIMEOUT(24'd100)) dut (
        .clk_sys_i     (clk),
        .reset_i       (rst),
        .c_rd_i        (c_rd),
        .c_wr_i        (c_wr),
        .c_lba0_i      (c_lba0),
        .c_lba1_i      (c_lba1),
        .c_done_o      (c_done),
        .c_err_o       (c_err),
        .c_busy_o      (c_busy),
        .c_buff_wr_o   (c_buff_wr),
        .c_buff_din0_i (c_buff_din0),
        .c_buff_din1_i (c_buff_din1),
        .sd_lba_o      (sd_lba),
        .sd_rd_o       (sd_rd),
        .sd_wr_o       (sd_wr),
        .sd_ack_i      (sd_ack),
        .sd_buff_wr_i  (sd_buff_wr),
        .sd_buff_din_o (sd_buff_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; c_rd = 2'b00; c_wr = 2'b00; c_lba0 = 32'd0; c_lba1 = 32'd0;
        c_buff_din0 = 8'h00; c_buff_din1 = 8'h00; sd_ack = 1'b0; sd_buff_wr = 1'b1;
        tick(); tick();
        n_vec++; if (sd_rd !== 2'b00) begin n_err++; $display("FAIL reset_rd: got %b want 00", sd_rd); end
        n_vec++; if (sd_wr !== 2'b00) begin n_err++; $display("FAIL reset_wr: got %b want 00", sd_wr); end
        n_vec++; if (sd_lba !== 32'd0) begin n_err++; $display("FAIL reset_lba: got %h want 0", sd_lba); end
        n_vec++; if ({c_done, c_err, c_busy} !== 6'd0) begin n_err++; $display("FAIL reset_flags: got %b want 000000", {c_done, c_err, c_busy}); end
        n_vec++; if (c_buff_wr !== 2'b00) begin n_err++; $display("FAIL reset_buffwr: got %b want 00", c_buff_wr); end
        rst = 1'b0; sd_buff_wr = 1'b0;
        tick();
    endtask

    task automatic test_read_c0();
        c_rd = 2'b01; c_lba0 = 32'h0000_1234;
        tick();
        n_vec++; if (sd_rd !== 2'b01) begin n_err++; $display("FAIL rd0_rd: got %b want 01", sd_rd); end
        n_vec++; if (sd_wr !== 2'b00) begin n_err++; $display("FAIL rd0_wr: got %b want 00", sd_wr); end
        n_vec++; if (sd_lba !== 32'h0000_1234) begin n_err++; $display("FAIL rd0_lba: got %h want 00001234", sd_lba); end
        n_vec++; if (c_busy !== 2'b01) begin n_err++; $display("FAIL rd0_busy: got %b want 01", c_busy); end
        c_lba0 = 32'hDEAD_BEEF;
        repeat (3) tick();
        n_vec++; if (sd_rd !== 2'b01 || sd_lba !== 32'h0000_1234) begin n_err++; $display("FAIL rd0_hold: got rd=%b lba=%h want 01/00001234", sd_rd, sd_lba); end
        sd_ack = 1'b1;
        tick();
        n_vec++; if (sd_rd !== 2'b00) begin n_err++; $display("FAIL rd0_ackdrop: got %b want 00", sd_rd); end
        repeat (9) tick();
        n_vec++; if (c_done !== 2'b00) begin n_err++; $display("FAIL rd0_early_done: got %b want 00", c_done); end
        sd_ack = 1'b0;
        tick();
        n_vec++; if (c_done !== 2'b01) begin n_err++; $display("FAIL rd0_done: got %b want 01", c_done); end
        n_vec++; if (c_err !== 2'b00) begin n_err++; $display("FAIL rd0_err: got %b want 00", c_err); end
        c_rd = 2'b00;
        tick();
        n_vec++; if (c_done !== 2'b00 || c_busy !== 2'b00) begin n_err++; $display("FAIL rd0_after: got done=%b busy=%b want 00/00", c_done, c_busy); end
        n_vec++; if (sd_lba !== 32'h0000_1234) begin n_err++; $display("FAIL rd0_lba_idle: got %h want 00001234", sd_lba); end
    endtask

    task automatic test_write_c1();
        int cnt0, cnt1, dbad;
        cnt0 = 0; cnt1 = 0; dbad = 0;
        c_wr = 2'b10; c_lba1 = 32'hABCD_0001; c_buff_din0 = 8'hC3; c_buff_din1 = 8'h5A;
        tick();
        n_vec++; if (sd_wr !== 2'b10 || sd_rd !== 2'b00) begin n_err++; $display("FAIL wr1_req: got wr=%b rd=%b want 10/00", sd_wr, sd_rd); end
        n_vec++; if (sd_lba !== 32'hABCD_0001) begin n_err++; $display("FAIL wr1_lba: got %h want abcd0001", sd_lba); end
        sd_buff_wr = 1'b1; #1;
        n_vec++; if (c_buff_wr !== 2'b00) begin n_err++; $display("FAIL wr1_issue_buffwr: got %b want 00", c_buff_wr); end
        sd_buff_wr = 1'b0;
        sd_ack = 1'b1;
        tick();
        for (int i = 0; i < 512; i++) begin
            c_buff_din1 = 8'(i * 7 + 3);
            sd_buff_wr = 1'b1; #1;
            if (c_buff_wr[1] === 1'b1) cnt1++;
            if (c_buff_wr[0] !== 1'b0) cnt0++;
            if (sd_buff_din !== 8'(i * 7 + 3)) dbad++;
            sd_buff_wr = 1'b0;
            tick();
            if (c_buff_wr !== 2'b00) cnt0++;
        end
        n_vec++; if (cnt1 !== 512) begin n_err++; $display("FAIL wr1_pulses1: got %0d want 512", cnt1); end
        n_vec++; if (cnt0 !== 0) begin n_err++; $display("FAIL wr1_stray_pulses: got %0d want 0", cnt0); end
        n_vec++; if (dbad !== 0) begin n_err++; $display("FAIL wr1_din: got %0d bad bytes want 0", dbad); end
        sd_ack = 1'b0;
        tick();
        n_vec++; if (c_done !== 2'b10) begin n_err++; $display("FAIL wr1_done: got %b want 10", c_done); end
        c_wr = 2'b00;
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] exp_oh;
        int k;
        rst = 1'b1; tick(); rst = 1'b0;
        c_lba0 = 32'h0000_0100; c_lba1 = 32'h0000_0200;
        c_rd = 2'b11;
        for (int j = 0; j < 4; j++) begin
            exp_oh = (j % 2 == 0) ? 2'b01 : 2'b10;
            k = 0;
            tick();
            while (sd_rd === 2'b00 && k < 10) begin tick(); k++; end
            n_vec++; if (sd_rd !== exp_oh) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", j, sd_rd, exp_oh); end
            n_vec++; if (sd_lba !== ((j % 2 == 0) ? 32'h100 : 32'h200)) begin n_err++; $display("FAIL rr_lba%0d: got %h", j, sd_lba); end
            sd_ack = 1'b1; tick();
            sd_ack = 1'b0; tick();
            n_vec++; if (c_done !== exp_oh) begin n_err++; $display("FAIL rr_done%0d: got %b want %b", j, c_done, exp_oh); end
        end
        c_rd = 2'b00;
        tick(); tick();
        n_vec++; if (sd_rd !== 2'b00) begin n_err++; $display("FAIL rr_quiet: got %b want 00", sd_rd); end
    endtask

    task automatic test_rd_wr_same_client();
        c_rd = 2'b01; c_wr = 2'b01; c_lba0 = 32'h0000_0055;
        tick();
        n_vec++; if (sd_wr !== 2'b01 || sd_rd !== 2'b00) begin n_err++; $display("FAIL both_op: got wr=%b rd=%b want 01/00", sd_wr, sd_rd); end
        sd_ack = 1'b1; tick();
        sd_ack = 1'b0; tick();
        n_vec++; if (c_done !== 2'b01) begin n_err++; $display("FAIL both_done: got %b want 01", c_done); end
        c_rd = 2'b00; c_wr = 2'b00;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        c_rd = 2'b01;
        tick();
`ifdef SD_ARB_TIMEOUT_EN
        n = 0;
        while (sd_rd === 2'b01 && n < 200) begin n++; tick(); end
        n_vec++; if (n !== 100) begin n_err++; $display("FAIL tmo_len: got %0d want 100", n); end
        n_vec++; if (c_done !== 2'b01 || c_err !== 2'b01) begin n_err++; $display("FAIL tmo_done: got done=%b err=%b want 01/01", c_done, c_err); end
        c_rd = 2'b00;
        tick();
        n_vec++; if (c_err !== 2'b00) begin n_err++; $display("FAIL tmo_err_clear: got %b want 00", c_err); end
`else
        n = 0;
        repeat (10000) begin
            tick();
            if (c_done !== 2'b00 || c_err !== 2'b00) n++;
        end
        n_vec++; if (sd_rd !== 2'b01) begin n_err++; $display("FAIL notmo_rd: got %b want 01", sd_rd); end
        n_vec++; if (n !== 0) begin n_err++; $display("FAIL notmo_flags: got %0d cycles with done/err want 0", n); end
        sd_ack = 1'b1; tick();
        sd_ack = 1'b0; tick();
        n_vec++; if (c_done !== 2'b01 || c_err !== 2'b00) begin n_err++; $display("FAIL notmo_done: got done=%b err=%b want 01/00", c_done, c_err); end
        c_rd = 2'b00;
        tick();
`endif
    endtask

    task automatic test_reset_mid_xfer();
        int nd;
        c_wr = 2'b01; c_lba0 = 32'h0000_0999;
        tick();
        sd_ack = 1'b1; tick();
        sd_buff_wr = 1'b1; #1;
        n_vec++; if (c_buff_wr !== 2'b01) begin n_err++; $display("FAIL rst_xfer_buffwr: got %b want 01", c_buff_wr); end
        rst = 1'b1;
        tick();
        rst = 1'b0; c_wr = 2'b00;
        n_vec++; if ({sd_rd, sd_wr, c_done, c_err, c_busy, c_buff_wr} !== 12'd0 || sd_lba !== 32'd0) begin n_err++; $display("FAIL rst_xfer_outs: got %b lba=%h want zeros", {sd_rd, sd_wr, c_done, c_err, c_busy, c_buff_wr}, sd_lba); end
        sd_ack = 1'b0; sd_buff_wr = 1'b0;
        nd = 0;
        repeat (3) begin tick(); if (c_done !== 2'b00) nd++; end
        n_vec++; if (nd !== 0) begin n_err++; $display("FAIL rst_xfer_nodone: got %0d done cycles want 0", nd); end
        c_rd = 2'b10; c_lba1 = 32'h0000_0077;
        tick();
        n_vec++; if (sd_rd !== 2'b10 || sd_lba !== 32'h77) begin n_err++; $display("FAIL rst_new_req: got rd=%b lba=%h want 10/00000077", sd_rd, sd_lba); end
        sd_ack = 1'b1; tick();
        sd_ack = 1'b0; tick();
        n_vec++; if (c_done !== 2'b10) begin n_err++; $display("FAIL rst_new_done: got %b want 10", c_done); end
        c_rd = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_read_c0();
        test_write_c1();
        test_contention();
        test_rd_wr_same_client();
        test_timeout();
        test_reset_mid_xfer();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
